// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text arbiter: default line length,
// FSM state encoding and width helpers used by the interface and the RTL.
package lcd_pkg;

  localparam int LINE_LENGTH_DEFAULT = 16;
  localparam int LINE_W_DEFAULT      = 8 * LINE_LENGTH_DEFAULT;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_DONE,
    RELEASE
  } lcd_arb_state_t;

  // Bit width of one text line holding line_length characters.
  function automatic int line_width(input int line_length);
    return 8 * line_length;
  endfunction

  // Width of a client index; never narrower than one bit.
  function automatic int idx_width(input int num_clients);
    return (num_clients > 1) ? $clog2(num_clients) : 1;
  endfunction

endpackage

// File: rtl/lcd_text_arbiter_if.sv
// Bundle of the client request side and the LCD controller text port.
// master: the arbiter's view (drives acks and the LCD text inputs).
// slave : the environment's view (clients plus LCD controller).
interface lcd_text_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int LINE_LENGTH = lcd_pkg::LINE_LENGTH_DEFAULT
);
  import lcd_pkg::*;

  localparam int LINE_W = line_width(LINE_LENGTH);

  logic [NUM_CLIENTS-1:0]             req;
  logic [NUM_CLIENTS-1:0][LINE_W-1:0] line1_in;
  logic [NUM_CLIENTS-1:0][LINE_W-1:0] line2_in;
  logic [NUM_CLIENTS-1:0]             ack;
  logic                               busy;
  logic                               lcd_sendText;
  logic [LINE_W-1:0]                  lcd_line1;
  logic [LINE_W-1:0]                  lcd_line2;
  logic                               lcd_sendingDone;
  logic                               timeout_err;

  modport master (
    input  req, line1_in, line2_in, lcd_sendingDone,
    output ack, busy, lcd_sendText, lcd_line1, lcd_line2, timeout_err
  );

  modport slave (
    output req, line1_in, line2_in, lcd_sendingDone,
    input  ack, busy, lcd_sendText, lcd_line1, lcd_line2, timeout_err
  );

endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin priority search: returns the first requesting
// client found by scanning upward from ptr, wrapping at NUM_CLIENTS.
module lcd_rr_pick #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = lcd_pkg::idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   any_req
);

  logic [IDX_W:0] cand;

  // Scan NUM_CLIENTS candidates starting at ptr; the first hit wins.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CLIENTS)) begin
        cand = cand - (IDX_W+1)'(NUM_CLIENTS);
      end
      if (!any_req && req[cand[IDX_W-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Shares one LCD controller text port between NUM_CLIENTS requesters.
// Round-robin grant, latch of the winner's two lines, one-cycle sendText
// pulse, wait for the controller's completion edge (bounded by a timeout),
// then a one-cycle ack back to the granted client.
// Optional feature macro: LCD_ARB_DEDUP_EN -- keeps a shadow of the last
// text actually sent and skips the transfer when a grant repeats it.
module lcd_text_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int LINE_LENGTH    = lcd_pkg::LINE_LENGTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                CLK,
  input  logic                RESET,
  lcd_text_arbiter_if.master  bus
);
  import lcd_pkg::*;

  localparam int LINE_W = line_width(LINE_LENGTH);
  localparam int IDX_W  = idx_width(NUM_CLIENTS);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);

  lcd_arb_state_t         state_q;
  lcd_arb_state_t         state_d;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       grant_q;
  logic [IDX_W-1:0]       pick_idx;
  logic                   any_req;
  logic [LINE_W-1:0]      line1_q;
  logic [LINE_W-1:0]      line2_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic                   done_prev_q;
  logic                   done_rise;
  logic                   at_limit;
  logic                   timeout_q;
  logic                   dedup_hit;
  logic [NUM_CLIENTS-1:0] ack_d;
  logic                   busy_d;
  logic                   send_d;

  lcd_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req       (bus.req),
    .ptr       (ptr_q),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  // Completion is a rising edge only, so a controller that holds
  // sendingDone high as a level cannot complete the next transfer early.
  assign done_rise = bus.lcd_sendingDone & ~done_prev_q;
  assign at_limit  = (wait_cnt_q == CNT_LAST);

`ifdef LCD_ARB_DEDUP_EN
  logic [LINE_W-1:0] shadow1_q;
  logic [LINE_W-1:0] shadow2_q;
  logic              shadow_valid_q;

  assign dedup_hit = shadow_valid_q && (line1_q == shadow1_q) && (line2_q == shadow2_q);

  // Remember the text of the last transfer the controller confirmed; a
  // timeout leaves the display contents unknown, so it invalidates the copy.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow1_q      <= '0;
      shadow2_q      <= '0;
      shadow_valid_q <= 1'b0;
    end else if (state_q == WAIT_DONE) begin
      if (done_rise) begin
        shadow1_q      <= line1_q;
        shadow2_q      <= line2_q;
        shadow_valid_q <= 1'b1;
      end else if (at_limit) begin
        shadow_valid_q <= 1'b0;
      end
    end
  end
`else
  assign dedup_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the state-decoded handshake outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b1;
    send_d  = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (any_req) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        state_d = dedup_hit ? RELEASE : SEND;
      end
      SEND: begin
        send_d  = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise || at_limit) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ack_d[grant_q] = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Track the previous sendingDone in every state so the edge detector is
  // already primed when WAIT_DONE is entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= bus.lcd_sendingDone;
    end
  end

  // Capture the winner and its text on the way into LATCH so the lines are
  // already stable during LATCH and stay put until the next grant.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_q <= '0;
      line1_q <= '0;
      line2_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      grant_q <= pick_idx;
      line1_q <= bus.line1_in[pick_idx];
      line2_q <= bus.line2_in[pick_idx];
    end
  end

  // Completion wait counter: cleared with the start pulse, counts WAIT_DONE cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt_q <= '0;
    end else if (state_q == SEND) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_DONE && !at_limit) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky timeout flag; a completion in the final cycle still counts as success.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timeout_q <= 1'b0;
    end else if (state_q == WAIT_DONE && at_limit && !done_rise) begin
      timeout_q <= 1'b1;
    end
  end

  // Move the round-robin pointer past the client just served.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr_q <= '0;
    end else if (state_q == RELEASE) begin
      ptr_q <= (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
    end
  end

  assign bus.ack          = ack_d;
  assign bus.busy         = busy_d;
  assign bus.lcd_sendText = send_d;
  assign bus.lcd_line1    = line1_q;
  assign bus.lcd_line2    = line2_q;
  assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Self-checking bench for lcd_text_arbiter with a small LCD controller model
// and a scoreboard of expected grants/texts.
module tb_lcd_text_arbiter;

  localparam int NC = 4;
  localparam int LL = 16;
  localparam int LW = 8 * LL;
  localparam int TO = 100;

  localparam int DONE_PULSE = 0;
  localparam int DONE_LEVEL = 1;
  localparam int DONE_STUCK = 2;

`ifdef LCD_ARB_DEDUP_EN
  localparam int REPEAT_SENDS   = 0;
  localparam int REPEAT_ACK_CYC = 1;
`else
  localparam int REPEAT_SENDS   = 1;
  localparam int REPEAT_ACK_CYC = 7;
`endif

  logic CLK;
  logic RESET;

  int checks     = 0;
  int failures   = 0;
  int done_mode  = DONE_PULSE;
  int done_delay = 10;

  int            exp_q[$];
  logic [LW-1:0] exp_line_q[$];

  lcd_text_arbiter_if #(.NUM_CLIENTS(NC), .LINE_LENGTH(LL)) bus ();

  lcd_text_arbiter #(
    .NUM_CLIENTS    (NC),
    .LINE_LENGTH    (LL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // LCD controller model: answers each sendText after done_delay cycles.
  initial begin
    bus.lcd_sendingDone = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.lcd_sendText === 1'b1 && done_mode != DONE_STUCK) begin
        repeat (done_delay) @(posedge CLK);
        #1;
        bus.lcd_sendingDone = 1'b1;
        if (done_mode == DONE_PULSE) begin
          @(posedge CLK);
          #1;
          bus.lcd_sendingDone = 1'b0;
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input int client, input logic [LW-1:0] l1, input logic [LW-1:0] l2);
    bus.line1_in[client] = l1;
    bus.line2_in[client] = l2;
    bus.req[client]      = 1'b1;
  endtask

  task automatic pulse_reset();
    RESET               = 1'b1;
    bus.req             = '0;
    bus.lcd_sendingDone = 1'b0;
    done_mode           = DONE_PULSE;
    exp_q.delete();
    exp_line_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  // Runs up to bound cycles, recording sendText activity, until an ack appears.
  task automatic wait_ack(input int bound, output logic [NC-1:0] ack_seen, output int ack_cyc,
                          output int send_cyc, output int sends,
                          output logic [LW-1:0] l1s, output logic [LW-1:0] l2s);
    ack_seen = '0;
    ack_cyc  = -1;
    send_cyc = -1;
    sends    = 0;
    l1s      = '0;
    l2s      = '0;
    for (int c = 0; c < bound; c++) begin
      @(posedge CLK);
      #1;
      if (bus.lcd_sendText === 1'b1) begin
        sends++;
        send_cyc = c;
        l1s      = bus.lcd_line1;
        l2s      = bus.lcd_line2;
      end
      if (bus.ack !== '0) begin
        ack_seen = bus.ack;
        ack_cyc  = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET               = 1'b1;
    bus.req             = '0;
    bus.line1_in        = '0;
    bus.line2_in        = '0;
    @(posedge CLK);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.ack !== '0) begin failures++; $display("[TB] FAIL reset_ack got=%b want=0", bus.ack); end
    checks++; if (bus.lcd_sendText !== 1'b0) begin failures++; $display("[TB] FAIL reset_send got=%b want=0", bus.lcd_sendText); end
    checks++; if (bus.lcd_line1 !== '0 || bus.lcd_line2 !== '0) begin failures++; $display("[TB] FAIL reset_lines got=%h/%h want=0", bus.lcd_line1, bus.lcd_line2); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout got=%b want=0", bus.timeout_err); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_single();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s, exp_line;
    pulse_reset();
    done_delay = 50;
    applyStimulus(2, LW'("HELLO"), LW'("WORLD"));
    exp_q.push_back(2);
    exp_line_q.push_back(LW'("HELLO"));
    wait_ack(200, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx  = exp_q.pop_front();
    exp_line = exp_line_q.pop_front();
    exp_ack  = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL single_ack got=%b want=%b", ack_seen, exp_ack); end
    checks++; if (sends != 1 || send_cyc != 1) begin failures++; $display("[TB] FAIL single_send got=%0d@%0d want=1@1", sends, send_cyc); end
    checks++; if (ack_cyc != 52) begin failures++; $display("[TB] FAIL single_latency got=%0d want=52", ack_cyc); end
    checks++; if (l1s !== exp_line || l2s !== LW'("WORLD")) begin failures++; $display("[TB] FAIL single_lines got=%h/%h want=%h", l1s, l2s, exp_line); end
    wait_ack(20, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    checks++; if (ack_seen !== '0 || sends != 0) begin failures++; $display("[TB] FAIL single_quiet got ack=%b sends=%0d want 0/0", ack_seen, sends); end
    checks++; if (bus.lcd_line1 !== exp_line) begin failures++; $display("[TB] FAIL single_hold got=%h want=%h", bus.lcd_line1, exp_line); end
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s, exp_line;
    int order[5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    done_delay = 10;
    for (int i = 0; i < NC; i++) begin
      applyStimulus(i, LW'(32'hC0DE_0000 + i), LW'(32'h5EC0_0000 + i));
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(order[i]);
      exp_line_q.push_back(LW'(32'hC0DE_0000 + order[i]));
    end
    for (int t = 0; t < 5; t++) begin
      wait_ack(100, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
      if (t == 4) bus.req = '0;
      exp_idx  = exp_q.pop_front();
      exp_line = exp_line_q.pop_front();
      exp_ack  = '0;
      exp_ack[exp_idx] = 1'b1;
      checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL rr_ack[%0d] got=%b want=%b", t, ack_seen, exp_ack); end
      checks++; if (l1s !== exp_line) begin failures++; $display("[TB] FAIL rr_line[%0d] got=%h want=%h", t, l1s, exp_line); end
    end
  endtask

  task automatic test_timeout();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s;
    pulse_reset();
    done_mode = DONE_STUCK;
    applyStimulus(3, LW'("STUCK"), LW'("DONE"));
    exp_q.push_back(3);
    wait_ack(300, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL timeout_ack got=%b want=%b", ack_seen, exp_ack); end
    checks++; if (ack_cyc - send_cyc != TO + 1) begin failures++; $display("[TB] FAIL timeout_wait got=%0d want=%0d", ack_cyc - send_cyc, TO + 1); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_flag got=%b want=1", bus.timeout_err); end
    done_mode  = DONE_PULSE;
    done_delay = 5;
    applyStimulus(0, LW'("AFTER"), LW'("TIMEOUT"));
    exp_q.push_back(0);
    wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL timeout_next_ack got=%b want=%b", ack_seen, exp_ack); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_sticky got=%b want=1", bus.timeout_err); end
    pulse_reset();
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_clear got=%b want=0", bus.timeout_err); end
  endtask

  task automatic test_reset_mid();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s;
    pulse_reset();
    done_delay = 3;
    applyStimulus(1, LW'("MOVE"), LW'("PTR"));
    exp_q.push_back(1);
    wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL mid_first_ack got=%b want=%b", ack_seen, exp_ack); end
    done_mode = DONE_STUCK;
    applyStimulus(3, LW'("ABORT"), LW'("ME"));
    repeat (10) @(posedge CLK);
    #1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy got=%b want=1", bus.busy); end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.ack !== '0 || bus.lcd_sendText !== 1'b0) begin failures++; $display("[TB] FAIL mid_ctrl got busy=%b ack=%b send=%b want 0", bus.busy, bus.ack, bus.lcd_sendText); end
    checks++; if (bus.lcd_line1 !== '0 || bus.lcd_line2 !== '0) begin failures++; $display("[TB] FAIL mid_lines got=%h/%h want=0", bus.lcd_line1, bus.lcd_line2); end
    applyStimulus(0, LW'("ZERO"), LW'("FIRST"));
    done_mode  = DONE_PULSE;
    exp_q.push_back(0);
    exp_q.push_back(3);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req[0] = 1'b0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL mid_ptr0_ack got=%b want=%b", ack_seen, exp_ack); end
    wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL mid_rereq_ack got=%b want=%b", ack_seen, exp_ack); end
  endtask

  task automatic test_level_done();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s;
    pulse_reset();
    done_mode  = DONE_LEVEL;
    done_delay = 5;
    applyStimulus(0, LW'("LEVEL"), LW'("ONE"));
    exp_q.push_back(0);
    wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack || ack_cyc != send_cyc + 6) begin failures++; $display("[TB] FAIL level_first got=%b@%0d want=%b@%0d", ack_seen, ack_cyc, exp_ack, send_cyc + 6); end
    applyStimulus(1, LW'("LEVEL"), LW'("TWO"));
    exp_q.push_back(1);
    wait_ack(30, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    checks++; if (ack_seen !== '0 || sends != 1) begin failures++; $display("[TB] FAIL level_no_edge got ack=%b sends=%0d want 0/1", ack_seen, sends); end
    bus.lcd_sendingDone = 1'b0;
    @(posedge CLK);
    #1;
    bus.lcd_sendingDone = 1'b1;
    wait_ack(10, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
    bus.req = '0;
    exp_idx = exp_q.pop_front();
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    checks++; if (ack_seen !== exp_ack || ack_cyc != 0) begin failures++; $display("[TB] FAIL level_new_edge got=%b@%0d want=%b@0", ack_seen, ack_cyc, exp_ack); end
    bus.lcd_sendingDone = 1'b0;
    done_mode = DONE_PULSE;
  endtask

  task automatic test_repeat_text();
    logic [NC-1:0] ack_seen, exp_ack;
    int ack_cyc, send_cyc, sends, exp_idx;
    logic [LW-1:0] l1s, l2s;
    pulse_reset();
    done_delay = 5;
    for (int r = 0; r < 3; r++) begin
      if (r < 2) applyStimulus(1, LW'("SAME"), LW'("TEXT"));
      else       applyStimulus(1, LW'("NEW"), LW'("TEXT"));
      exp_q.push_back(1);
      wait_ack(50, ack_seen, ack_cyc, send_cyc, sends, l1s, l2s);
      bus.req = '0;
      exp_idx = exp_q.pop_front();
      exp_ack = '0;
      exp_ack[exp_idx] = 1'b1;
      checks++; if (ack_seen !== exp_ack) begin failures++; $display("[TB] FAIL repeat_ack[%0d] got=%b want=%b", r, ack_seen, exp_ack); end
      if (r == 1) begin
        checks++; if (sends != REPEAT_SENDS || ack_cyc != REPEAT_ACK_CYC) begin failures++; $display("[TB] FAIL repeat_same got sends=%0d ack@%0d want %0d/%0d", sends, ack_cyc, REPEAT_SENDS, REPEAT_ACK_CYC); end
      end else begin
        checks++; if (sends != 1 || ack_cyc != 7) begin failures++; $display("[TB] FAIL repeat_full[%0d] got sends=%0d ack@%0d want 1/7", r, sends, ack_cyc); end
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_level_done();
    test_repeat_text();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
